// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM sharing one ALU and one unified memory,
// with a req/ready handshake and a watchdog that aborts stalled memory accesses.
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [3:0] state_out,
  output logic       illegal,
  output logic       mem_timeout
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001, ALU_SLT = 4'b0111;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic abort, wait_st, to_hit, ill_set;
  // abort marks the cycle after a timeout, where the request is withdrawn
  assign wait_st = (state == FETCH && !abort) || state == MEMRD || state == MEMWR;
  assign cnt_inc = cnt + CNT_W'(1);
  assign to_hit = wait_st && !mem_ready && cnt_inc == CNT_W'(WAIT_LIMIT);
  always_comb begin
    state_n = state;
    ill_set = 1'b0;
    {mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl,
     reg_dst, mem_to_reg, reg_write} = 17'd0;
    case (state)
      FETCH: begin
        mem_req = !abort;
        alu_src_b = 2'b01;
        alu_ctrl = ALU_ADD;
        ir_write = mem_ready && !abort;
        pc_en = mem_ready && !abort;
        state_n = (mem_ready && !abort) ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXEC;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JUMP;
          default: begin
            ill_set = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl = ALU_ADD;
        state_n = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        i_or_d = 1'b1;
        state_n = mem_ready ? MEMWB : to_hit ? FETCH : MEMRD;
      end
      MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        state_n = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        i_or_d = 1'b1;
        state_n = (mem_ready || to_hit) ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        state_n = ALUWB;
        case (funct)
          6'h20: alu_ctrl = ALU_ADD;
          6'h22: alu_ctrl = ALU_SUB;
          6'h24: alu_ctrl = ALU_AND;
          6'h25: alu_ctrl = ALU_OR;
          6'h2A: alu_ctrl = ALU_SLT;
          default: begin
            ill_set = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl = ALU_SUB;
        pc_src = 2'b01;
        pc_en = zero;
        state_n = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl = ALU_ADD;
        state_n = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_n = FETCH;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    if (reset)
      {mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctrl,
       reg_dst, mem_to_reg, reg_write} = 17'd0;
  end
  assign state_out = reset ? 4'd0 : state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt <= '0;
      abort <= 1'b0;
      illegal <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (wait_st && !mem_ready && !to_hit) ? cnt_inc : '0;
      abort <= to_hit;
      illegal <= illegal | ill_set;
      mem_timeout <= mem_timeout | to_hit;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench for the multi-cycle control FSM; each cycle's
// expected control word (outputs plus sticky flags) is queued with the stimulus and popped on sampling.
module tb_mips_multicycle_ctrl;
  logic clk, reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, mem_we, i_or_d, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write;
  logic illegal, mem_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state_out;
  logic [22:0] obs, want;
  logic [22:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  mips_multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state_out(state_out),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  assign obs = {state_out, mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, illegal, mem_timeout};

  // mem = {req, we, i_or_d, ir_write, pc_en}; wb = {reg_dst, mem_to_reg, reg_write}
  function automatic logic [22:0] o(input logic [3:0] st, input logic [4:0] mem,
                                    input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
                                    input logic [3:0] alu, input logic [2:0] wb);
    return {st, mem, pcs, asa, asb, alu, wb, 2'b00};
  endfunction

  localparam logic [22:0] TO = 23'd1, IL = 23'd2;
  localparam logic [22:0] F_W = o(4'd0, 5'b10000, 2'b00, 1'b0, 2'b01, 4'b0010, 3'b000);
  localparam logic [22:0] F_R = o(4'd0, 5'b10011, 2'b00, 1'b0, 2'b01, 4'b0010, 3'b000);
  localparam logic [22:0] F_A = o(4'd0, 5'b00000, 2'b00, 1'b0, 2'b01, 4'b0010, 3'b000);
  localparam logic [22:0] D   = o(4'd1, 5'b00000, 2'b00, 1'b0, 2'b11, 4'b0010, 3'b000);
  localparam logic [22:0] MA  = o(4'd2, 5'b00000, 2'b00, 1'b1, 2'b10, 4'b0010, 3'b000);
  localparam logic [22:0] MR  = o(4'd3, 5'b10100, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000);
  localparam logic [22:0] WB  = o(4'd4, 5'b00000, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b011);
  localparam logic [22:0] MW  = o(4'd5, 5'b11100, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000);
  localparam logic [22:0] EXS = o(4'd6, 5'b00000, 2'b00, 1'b1, 2'b00, 4'b0110, 3'b000);
  localparam logic [22:0] EXX = o(4'd6, 5'b00000, 2'b00, 1'b1, 2'b00, 4'b0000, 3'b000);
  localparam logic [22:0] AW  = o(4'd7, 5'b00000, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b101);
  localparam logic [22:0] BR1 = o(4'd8, 5'b00001, 2'b01, 1'b1, 2'b00, 4'b0110, 3'b000);
  localparam logic [22:0] BR0 = o(4'd8, 5'b00000, 2'b01, 1'b1, 2'b00, 4'b0110, 3'b000);
  localparam logic [22:0] AE  = o(4'd9, 5'b00000, 2'b00, 1'b1, 2'b10, 4'b0010, 3'b000);
  localparam logic [22:0] AWB = o(4'd10, 5'b00000, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b001);
  localparam logic [22:0] J   = o(4'd11, 5'b00001, 2'b10, 1'b0, 2'b00, 4'b0000, 3'b000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic r,
                       input logic z, input logic [22:0] e);
    @(negedge clk);
    opcode = op;
    funct = fn;
    mem_ready = r;
    zero = z;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = (i == 0);
      zero = (i == 1);
      opcode = (i == 0) ? 6'h23 : 6'h04;
      exp_q.push_back(23'd0);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs, want);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(6'h00, 6'h20, 1'b0, 1'b0, F_W);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, want);
    end
  endtask

  task automatic test_rtype();
    logic [22:0] e[5];
    logic r[5];
    e = '{F_R, D, EXS, AW, F_W};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(6'h00, 6'h22, r[i], 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL rtype[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_lw();
    logic [22:0] e[8];
    logic r[8];
    e = '{F_R, D, MA, MR, MR, MR, WB, F_W};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(6'h23, 6'h00, r[i], 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL lw[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_sw();
    logic [22:0] e[5];
    logic r[5];
    e = '{F_R, D, MA, MW, F_W};
    r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(6'h2B, 6'h00, r[i], 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL sw[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_beq();
    logic [22:0] e[7];
    logic r[7];
    logic z[7];
    e = '{F_R, D, BR1, F_R, D, BR0, F_W};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    z = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(6'h04, 6'h00, r[i], z[i], e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL beq[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_addi_jump();
    logic [22:0] e[8];
    logic [5:0] op[8];
    e = '{F_R, D, AE, AWB, F_R, D, J, F_W};
    op = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h02, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 8; i++) begin
      drive(op[i], 6'h00, i != 7, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL addi_jump[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_timeout();
    logic [22:0] e[9];
    logic r[9];
    e = '{F_W, F_W, F_W, F_W, F_A | TO, F_R | TO, D | TO, J | TO, F_W | TO};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      drive(6'h02, 6'h00, r[i], 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL timeout[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    logic [22:0] e[7];
    logic r[7];
    e = '{F_W, F_W, F_W, F_R, D, J, F_W};
    r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      drive(6'h02, 6'h00, r[i], 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL boundary[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [22:0] e[4];
    logic [22:0] e2[3];
    e = '{F_R, D, EXX, F_W | IL};
    for (int i = 0; i < 4; i++) begin
      drive(6'h00, 6'h01, i != 3, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL illegal_funct[%0d] got=%h want=%h", i, obs, want);
      end
    end
    pulse_reset();
    e2 = '{F_R, D, F_W | IL};
    for (int i = 0; i < 3; i++) begin
      drive(6'h3F, 6'h20, i != 2, 1'b0, e2[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL illegal_op[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [22:0] e[4];
    logic [22:0] e2[5];
    e = '{F_R | IL, D | IL, MA | IL, MW | IL};
    for (int i = 0; i < 4; i++) begin
      drive(6'h2B, 6'h00, i != 3, 1'b0, e[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL pre_reset[%0d] got=%h want=%h", i, obs, want);
      end
    end
    #1 reset = 1'b1;
    exp_q.push_back(23'd0);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs, want);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    e2 = '{F_R, D, MA, MW, F_W};
    for (int i = 0; i < 5; i++) begin
      drive(6'h2B, 6'h00, i != 4, 1'b0, e2[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL post_reset[%0d] got=%h want=%h", i, obs, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    opcode = 6'h23;
    funct = 6'h20;
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_addi_jump();
    test_timeout();
    test_timeout_boundary();
    test_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
